cmp_share_arb: RTL and testbench

- Shares one comparatortree instance (64-bit EQ / signed LT / unsigned LTu) among NREQ requesters.
- Round-robin arbitration, valid/ready handshakes on both sides, and a two-stage pipeline: operand register, then compare and result register.
- Sits between the integer, branch and FP-compare clients and the single physical comparator, to save area.
- Sustains one comparison per cycle with in-order responses tagged by requester id.

---
 rtl/cmp_arb_pkg.sv | 36 +++
 rtl/comparatortree.sv | 19 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/cmp_share_arb.sv | 121 ++++++++++++
 tb/tb_cmp_share_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared types, defaults and the rotate-priority pick used by the comparator arbiter.
package cmp_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = $clog2(NREQ_DEF);
    localparam int MAXREQ   = 16;
    localparam int MAXIDW   = 4;

    // One comparison result as it leaves the second pipeline stage.
    typedef struct packed {
        logic [MAXIDW-1:0] id;
        logic              eq;
        logic              lt;
        logic              ltu;
    } rsp_t;

    // One-hot grant for the first set bit of req, scanning ptr, ptr+1, ... modulo n.
    function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] req,
                                                  input logic [MAXIDW-1:0] ptr,
                                                  input int n);
        logic [MAXREQ-1:0] g;
        logic              found;
        logic [MAXIDW-1:0] idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAXREQ; k++) begin
            idx = MAXIDW'((int'(ptr) + k) % n);
            if (k < n && !found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/comparatortree.sv
// 64-bit magnitude/equality comparator: equality, signed less-than, unsigned less-than.
module comparatortree #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             ltu
);

    // Pure combinational compare; equal operands force both less-than flags low.
    always_comb begin
        eq  = (a == b);
        ltu = (a < b);
        lt  = ($signed(a) < $signed(b));
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority pointer plus rotate-priority encode.
module rr_arbiter
    import cmp_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    input  logic            flush,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);

    logic [IDW-1:0] ptr;
    logic           take;

    // Pick the first requester at or after ptr, wrapping around.
    always_comb begin
        grant = NREQ'(rr_pick(MAXREQ'(req), MAXIDW'(ptr), NREQ));
    end

    // Encode the one-hot grant into a requester index.
    always_comb begin
        id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) id = IDW'(i);
        end
    end

    assign take = (|grant) & adv & ~flush;

    // After a transfer the winner drops to lowest priority; otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
        end
    end

endmodule

// File: rtl/cmp_share_arb.sv
// Shares one comparatortree among NREQ requesters through a round-robin
// arbiter and a two-register pipeline (operand stage S1, result stage S2).
//
// Handshake: on both sides a transfer happens on a rising edge where valid
// and ready are both high. Requesters hold valid and operands stable until
// granted; ready may change every cycle (grants are not sticky). The
// response side holds RspId/flags stable while RspValid is high and
// RspReady is low.
module cmp_share_arb
    import cmp_arb_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int NREQ  = NREQ_DEF,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Flush,
    input  logic [NREQ-1:0]       ReqValid,
    output logic [NREQ-1:0]       ReqReady,
    input  logic [NREQ*WIDTH-1:0] ReqA,
    input  logic [NREQ*WIDTH-1:0] ReqB,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [IDW-1:0]        RspId,
    output logic                  RspEQ,
    output logic                  RspLT,
    output logic                  RspLTu
);

    logic             v1, v2;
    logic [WIDTH-1:0] a1, b1;
    logic [IDW-1:0]   id1;
    rsp_t             s2;

    logic             adv2, acc1, xfer;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gid;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             c_eq, c_lt, c_ltu;

    assign adv2 = ~v2 | RspReady;
    assign acc1 = ~v1 | adv2;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (ReqValid),
        .adv   (acc1),
        .flush (Flush),
        .grant (grant),
        .id    (gid)
    );

    assign ReqReady = grant & {NREQ{acc1 & ~Flush}};
    assign xfer     = |ReqReady;

    // Route the granted requester's operands into S1.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel = ReqA[i*WIDTH +: WIDTH];
                b_sel = ReqB[i*WIDTH +: WIDTH];
            end
        end
    end

    // Stage 1: operand register; flush drops the valid but keeps the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            id1 <= '0;
        end else if (Flush) begin
            v1 <= 1'b0;
        end else if (xfer) begin
            v1  <= 1'b1;
            a1  <= a_sel;
            b1  <= b_sel;
            id1 <= gid;
        end else if (adv2) begin
            v1 <= 1'b0;
        end
    end

    comparatortree #(.WIDTH(WIDTH)) u_cmp (
        .a   (a1),
        .b   (b1),
        .eq  (c_eq),
        .lt  (c_lt),
        .ltu (c_ltu)
    );

    // Stage 2: result register; a consumed response is replaced or retired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2 <= 1'b0;
            s2 <= '0;
        end else if (Flush) begin
            v2 <= 1'b0;
        end else if (v1 && adv2) begin
            v2     <= 1'b1;
            s2.id  <= MAXIDW'(id1);
            s2.eq  <= c_eq;
            s2.lt  <= c_lt;
            s2.ltu <= c_ltu;
        end else if (RspReady) begin
            v2 <= 1'b0;
        end
    end

    assign RspValid = v2;
    assign RspId    = IDW'(s2.id);
    assign RspEQ    = s2.eq;
    assign RspLT    = s2.lt;
    assign RspLTu   = s2.ltu;

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed bench for cmp_share_arb: arbitration order, pipeline timing,
// backpressure, flush and asynchronous reset.
module tb_cmp_share_arb;

    localparam int W = 64;
    localparam int N = 4;

    logic             clk;
    logic             reset;
    logic             flush;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic             rsp_eq;
    logic             rsp_lt;
    logic             rsp_ltu;

    int total;
    int bad;

    logic [1:0] exp_q[$];
    logic       tab_eq [N];
    logic       tab_lt [N];
    logic       tab_ltu[N];

    cmp_share_arb #(.WIDTH(W), .NREQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .Flush    (flush),
        .ReqValid (req_valid),
        .ReqReady (req_ready),
        .ReqA     (req_a),
        .ReqB     (req_b),
        .RspValid (rsp_valid),
        .RspReady (rsp_ready),
        .RspId    (rsp_id),
        .RspEQ    (rsp_eq),
        .RspLT    (rsp_lt),
        .RspLTu   (rsp_ltu)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        total++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b id=%0d flags=%b%b%b want 0 0 000",
                     rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
        end
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL after_reset: got v=%b ready=%b want 0 0000", rsp_valid, req_ready);
        end
    endtask

    task automatic test_single;
        rsp_ready = 1'b1;
        set_op(0, 64'd5, 64'd7);
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early: got v=%b want 0", rsp_valid);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b011) begin
            bad++;
            $display("FAIL single_rsp: got v=%b id=%0d flags=%b%b%b want 1 0 011",
                     rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_signed_split;
        // Pointer sits at 1 after the single-request test.
        set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        set_op(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL split_ready2: got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL split_ready3: got %b want 1000", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b010) begin
            bad++;
            $display("FAIL split_neg: got v=%b id=%0d flags=%b%b%b want 1 2 010",
                     rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b100) begin
            bad++;
            $display("FAIL split_eq: got v=%b id=%0d flags=%b%b%b want 1 3 100",
                     rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL split_drain: got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic load_table_ops;
        set_op(0, 64'd3, 64'd3);
        set_op(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5);
        set_op(2, 64'd10, 64'd4);
        set_op(3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        tab_eq  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tab_lt  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tab_ltu = '{1'b0, 1'b0, 1'b0, 1'b1};
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        load_table_ops();
        rsp_ready = 1'b1;
        exp_q.delete();
        // Pointer is back at 0: grants 0,1,2,3 repeating, results two edges later.
        for (int c = 0; c < 14; c++) begin
            if (c >= 2) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rr_queue: cycle %0d nothing expected", c);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_valid !== 1'b1 || rsp_id !== e ||
                        {rsp_eq, rsp_lt, rsp_ltu} !== {tab_eq[e], tab_lt[e], tab_ltu[e]}) begin
                        bad++;
                        $display("FAIL rr_rsp: cycle %0d got v=%b id=%0d flags=%b%b%b want 1 %0d %b%b%b",
                                 c, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu,
                                 e, tab_eq[e], tab_lt[e], tab_ltu[e]);
                    end
                end
            end
            if (c < 12) begin
                req_valid = 4'b1111;
                #1;
                total++;
                if (req_ready !== (4'b0001 << (c % 4))) begin
                    bad++;
                    $display("FAIL rr_grant: cycle %0d got %b want %b", c, req_ready, 4'b0001 << (c % 4));
                end
                exp_q.push_back(2'(c % 4));
            end else begin
                req_valid = 4'b0000;
            end
            tick();
        end
        total++;
        if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rr_end: got v=%b left=%0d want 0 0", rsp_valid, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] want;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        // Pointer at 0: requester 0 then 1 get in, then the pipe is full.
        for (int c = 0; c < 6; c++) begin
            #1;
            want = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000;
            total++;
            if (req_ready !== want) begin
                bad++;
                $display("FAIL bp_ready: cycle %0d got %b want %b", c, req_ready, want);
            end
            tick();
            if (c >= 1) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b100) begin
                    bad++;
                    $display("FAIL bp_hold: cycle %0d got v=%b id=%0d flags=%b%b%b want 1 0 100",
                             c, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
                end
            end
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b010) begin
            bad++;
            $display("FAIL bp_release: got v=%b id=%0d flags=%b%b%b want 1 1 010",
                     rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_flush;
        // Pointer at 2: fill the pipe with requesters 2 and 3.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
            bad++;
            $display("FAIL flush_fill: got v=%b id=%0d want 1 2", rsp_valid, rsp_id);
        end
        flush = 1'b1;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL flush_ready: got %b want 0000", req_ready);
        end
        tick();
        flush = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_valid: got v=%b want 0", rsp_valid);
        end
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL flush_ptr: got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_ghost: got v=%b id=%0d want 0", rsp_valid, rsp_id);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b100) begin
            bad++;
            $display("FAIL flush_next: got v=%b id=%0d flags=%b%b%b want 1 0 100",
                     rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_drain: got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_async_reset;
        // Pointer at 1: requesters 1 and 2 enter the pipe.
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        tick();
        tick();
        req_valid = 4'b0000;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b010) begin
            bad++;
            $display("FAIL ar_before: got v=%b id=%0d flags=%b%b%b want 1 1 010",
                     rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b000) begin
            bad++;
            $display("FAIL ar_clear: got v=%b id=%0d flags=%b%b%b want 0 0 000",
                     rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
        end
        tick();
        reset = 1'b0;
        req_valid = 4'b1010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL ar_first: got %b want 0010", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || {rsp_eq, rsp_lt, rsp_ltu} !== 3'b010) begin
            bad++;
            $display("FAIL ar_rsp: got v=%b id=%0d flags=%b%b%b want 1 1 010",
                     rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL ar_drain: got v=%b want 0", rsp_valid);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        test_reset();
        test_single();
        test_signed_split();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
